// File: rtl/cas_player.sv
// Cassette image player: streams a byte image from RAM as 1200/2400 Hz FSK,
// replacing 8-byte block headers with a pilot tone (and a silence gap before non-first headers).
module cas_player #(
  parameter int HALF_TICKS = 746,
  parameter int LONG_SYNC  = 16000,
  parameter int SHORT_SYNC = 4000,
  parameter int GAP_TICKS  = 3579545
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        ce_3m58_p,
  input  logic        cas_motor,
  input  logic        img_load,
  input  logic [26:0] img_size,
  input  logic [26:0] img_base,
  output logic [26:0] ram_addr,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic [7:0]  ram_dout,
  output logic        cas_audio_in,
  output logic        playing,
  output logic        end_of_tape
);

  // IDLE wait load | FETCH read chunk | CHECK header? | GAP silence | SYNC pilot ones | SEND framed bytes | DONE end
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, GAP, SYNC, SEND, DONE} state_t;

  localparam logic [21:0] C_HALF  = 22'(HALF_TICKS - 1);
  localparam logic [21:0] C_GAP   = 22'(GAP_TICKS - 1);
  localparam logic [13:0] C_LONG  = 14'(LONG_SYNC - 1);
  localparam logic [13:0] C_SHORT = 14'(SHORT_SYNC - 1);
  localparam logic [63:0] C_HDR   = 64'h747D_13CC_BADE_A61F;

  state_t      r_state, w_next;
  logic [26:0] r_offset, r_size, r_addr;
  logic [7:0]  r_buf [8];
  logic [3:0]  r_idx, r_cnt, r_bitpos;
  logic [2:0]  r_byte;
  logic        r_req;
  logic [21:0] r_tick;
  logic [1:0]  r_slot;
  logic [13:0] r_bits;

  logic        w_adv, w_at_end, w_fetch_done, w_hdr, w_half_end, w_bit_end, w_last_byte;
  logic        w_bit, w_level;
  logic [26:0] w_remain;
  logic [3:0]  w_fetch_len;
  logic [7:0]  w_cur_byte;

  assign w_adv        = ce_3m58_p & cas_motor;
  assign w_remain     = r_size - r_offset;
  assign w_fetch_len  = (w_remain >= 27'd8) ? 4'd8 : w_remain[3:0];
  assign w_at_end     = r_offset >= r_size;
  assign w_fetch_done = !r_req && (r_idx == w_fetch_len);
  assign w_hdr        = (r_cnt == 4'd8) &&
                        ({r_buf[7], r_buf[6], r_buf[5], r_buf[4],
                          r_buf[3], r_buf[2], r_buf[1], r_buf[0]} == C_HDR);
  assign w_half_end   = w_adv && (r_tick == 22'd0);
  assign w_bit_end    = w_half_end && (r_slot == 2'd3);
  assign w_last_byte  = ({1'b0, r_byte} == (r_cnt - 4'd1));
  assign w_cur_byte   = r_buf[r_byte];

  always_comb begin
    w_bit = 1'b1;
    if (r_state == SEND) begin
      if (r_bitpos == 4'd0)
        w_bit = 1'b0;
      else if (r_bitpos <= 4'd8)
        w_bit = w_cur_byte[3'(r_bitpos - 4'd1)];
    end
  end

  // '1' toggles every half-slot (2400 Hz), '0' every two half-slots (1200 Hz)
  assign w_level      = w_bit ? ~r_slot[0] : ~r_slot[1];
  assign cas_audio_in = cas_motor && ((r_state == SYNC) || (r_state == SEND)) && w_level;
  assign playing      = cas_motor && ((r_state == GAP) || (r_state == SYNC) || (r_state == SEND));
  assign end_of_tape  = (r_state == DONE);
  assign ram_req      = r_req;
  assign ram_addr     = r_addr;

  always_ff @(posedge clk21m) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: if (w_at_end) w_next = DONE;
             else if (w_fetch_done) w_next = CHECK;
      CHECK: if (w_hdr) w_next = (r_offset == 27'd0) ? SYNC : GAP;
             else w_next = SEND;
      GAP:   if (w_half_end) w_next = SYNC;
      SYNC:  if (w_bit_end && (r_bits == 14'd0)) w_next = FETCH;
      SEND:  if (w_bit_end && (r_bitpos == 4'd10) && w_last_byte)
               w_next = w_at_end ? DONE : FETCH;
      default: ;
    endcase
    if (img_load)
      w_next = (img_size != 27'd0) ? FETCH : DONE;
  end

  always_ff @(posedge clk21m) begin
    if (reset) begin
      r_offset <= '0;
      r_size   <= '0;
      r_addr   <= '0;
      r_req    <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_tick   <= '0;
      r_slot   <= '0;
      r_bits   <= '0;
      r_bitpos <= '0;
      r_byte   <= '0;
      for (int i = 0; i < 8; i++) r_buf[i] <= '0;
    end else if (img_load) begin
      r_offset <= '0;
      r_size   <= img_size;
      r_req    <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_tick   <= '0;
      r_slot   <= '0;
      r_bits   <= '0;
      r_bitpos <= '0;
      r_byte   <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_req) begin
            if (ram_ack) begin
              r_buf[r_idx[2:0]] <= ram_dout;
              r_idx             <= r_idx + 4'd1;
              r_req             <= 1'b0;
            end
          end else if (!w_at_end) begin
            if (r_idx != w_fetch_len) begin
              r_req  <= 1'b1;
              r_addr <= img_base + r_offset + 27'(r_idx);
            end else begin
              r_cnt <= w_fetch_len;
              r_idx <= '0;
            end
          end
        end
        CHECK: begin
          r_slot <= '0;
          if (w_hdr) begin
            r_offset <= r_offset + 27'd8;
            r_bits   <= (r_offset == 27'd0) ? C_LONG : C_SHORT;
            r_tick   <= (r_offset == 27'd0) ? C_HALF : C_GAP;
          end else begin
            r_offset <= r_offset + 27'(r_cnt);
            r_byte   <= '0;
            r_bitpos <= '0;
            r_tick   <= C_HALF;
          end
        end
        GAP: if (w_adv) r_tick <= (r_tick == 22'd0) ? C_HALF : r_tick - 22'd1;
        SYNC, SEND: begin
          if (w_adv) begin
            if (r_tick != 22'd0) begin
              r_tick <= r_tick - 22'd1;
            end else begin
              r_tick <= C_HALF;
              r_slot <= r_slot + 2'd1;
              if (r_slot == 2'd3) begin
                if (r_state == SYNC) begin
                  if (r_bits != 14'd0) r_bits <= r_bits - 14'd1;
                end else if (r_bitpos == 4'd10) begin
                  r_bitpos <= '0;
                  r_byte   <= r_byte + 3'd1;
                end else begin
                  r_bitpos <= r_bitpos + 4'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Bench for cas_player: a reference model expands each image into per-tick audio levels,
// a monitor pops them on every played tick, and a RAM model checks the read handshake.
module tb_cas_player;

  localparam int HALF  = 2;
  localparam int LONG  = 4;
  localparam int SHORT = 3;
  localparam int GAPT  = 10;

  logic        clk21m = 1'b0;
  logic        reset = 1'b1;
  logic        ce_3m58_p = 1'b0;
  logic        cas_motor = 1'b1;
  logic        img_load = 1'b0;
  logic [26:0] img_size = '0;
  logic [26:0] img_base = '0;
  logic [26:0] ram_addr;
  logic        ram_req;
  logic        ram_ack = 1'b0;
  logic [7:0]  ram_dout = '0;
  logic        cas_audio_in, playing, end_of_tape;

  int          n_vec = 0;
  int          n_miss = 0;
  logic        exp_q[$];
  logic [26:0] reads[$];
  logic [7:0]  img[$];
  logic [7:0]  mem [0:4095];
  int          mem_delay = -1;
  bit          late_arm = 1'b0;
  bit          in_flight = 1'b0;
  logic [26:0] held_addr = '0;
  int          wait_left = 0;
  logic        lvl;

  cas_player #(.HALF_TICKS(HALF), .LONG_SYNC(LONG), .SHORT_SYNC(SHORT), .GAP_TICKS(GAPT)) dut (
    .clk21m(clk21m), .reset(reset), .ce_3m58_p(ce_3m58_p), .cas_motor(cas_motor),
    .img_load(img_load), .img_size(img_size), .img_base(img_base),
    .ram_addr(ram_addr), .ram_req(ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout),
    .cas_audio_in(cas_audio_in), .playing(playing), .end_of_tape(end_of_tape)
  );

  always #5 clk21m = ~clk21m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk21m); #1;
    ce_3m58_p = ($urandom_range(0, 2) != 0);
  end

  // RAM responder: acks after a delay, checks the address holds while waiting
  initial forever begin
    @(posedge clk21m); #1;
    ram_ack = 1'b0;
    if (ram_req) begin
      if (!in_flight) begin
        in_flight = 1'b1;
        held_addr = ram_addr;
        reads.push_back(ram_addr);
        wait_left = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end else begin
        chk("addr_stable", ram_addr, held_addr);
      end
      if (wait_left == 0) begin
        ram_ack   = 1'b1;
        ram_dout  = mem[held_addr[11:0]];
        in_flight = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      in_flight = 1'b0;
      if (late_arm) begin
        ram_ack  = 1'b1;
        ram_dout = 8'hEE;
        late_arm = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk21m);
    if (!cas_motor) begin
      chk("pause_audio", {31'b0, cas_audio_in}, 32'd0);
      chk("pause_playing", {31'b0, playing}, 32'd0);
    end else if (playing && ce_3m58_p) begin
      if (exp_q.size() == 0) begin
        chk("extra_tick", {31'b0, playing}, 32'd0);
      end else begin
        lvl = exp_q.pop_front();
        chk("level", {31'b0, cas_audio_in}, {31'b0, lvl});
      end
    end
  end

  task automatic push_bit(input logic b);
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < HALF; t++)
        exp_q.push_back(b ? (s % 2 == 0) : (s < 2));
  endtask

  task automatic build_expected();
    logic [7:0] hdr [8];
    int pos;
    int n;
    bit is_hdr;
    int c;
    hdr = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};
    exp_q.delete();
    pos = 0;
    n = img.size();
    while (pos < n) begin
      is_hdr = (pos % 8 == 0) && (n - pos >= 8);
      if (is_hdr)
        for (int k = 0; k < 8; k++) if (img[pos + k] != hdr[k]) is_hdr = 1'b0;
      if (is_hdr) begin
        if (pos != 0) repeat (GAPT) exp_q.push_back(1'b0);
        repeat ((pos == 0) ? LONG : SHORT) push_bit(1'b1);
        pos += 8;
      end else begin
        c = (n - pos < 8) ? n - pos : 8;
        for (int k = 0; k < c; k++) begin
          push_bit(1'b0);
          for (int j = 0; j < 8; j++) push_bit(img[pos + k][j]);
          push_bit(1'b1);
          push_bit(1'b1);
        end
        pos += c;
      end
    end
  endtask

  task automatic set_hdr(input int at);
    logic [7:0] hdr [8];
    hdr = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};
    for (int k = 0; k < 8; k++) img[at + k] = hdr[k];
  endtask

  task automatic load_image(input logic [26:0] base);
    for (int k = 0; k < img.size(); k++) mem[12'(base + 27'(k))] = img[k];
    build_expected();
    reads.delete();
    img_base = base;
    img_size = 27'(img.size());
    img_load = 1'b1;
    @(posedge clk21m); #1;
    img_load = 1'b0;
  endtask

  task automatic finish_image(input logic [26:0] base, input string tag);
    int cyc;
    cyc = 0;
    while (!end_of_tape && cyc < 40000) begin
      @(posedge clk21m); #1;
      cyc++;
    end
    chk({tag, "_eot"}, {31'b0, end_of_tape}, 32'd1);
    chk({tag, "_leftover"}, exp_q.size(), 32'd0);
    chk({tag, "_nreads"}, reads.size(), img.size());
    for (int k = 0; k < reads.size() && k < img.size(); k++)
      chk({tag, "_addr"}, {5'b0, reads[k]}, {5'b0, base + 27'(k)});
  endtask

  task automatic rand_image(input int n);
    img.delete();
    for (int k = 0; k < n; k++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 4096; k++) mem[k] = '0;

    repeat (3) @(posedge clk21m);
    #1;
    chk("rst_req", {31'b0, ram_req}, 32'd0);
    chk("rst_addr", {5'b0, ram_addr}, 32'd0);
    chk("rst_audio", {31'b0, cas_audio_in}, 32'd0);
    chk("rst_playing", {31'b0, playing}, 32'd0);
    chk("rst_eot", {31'b0, end_of_tape}, 32'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk21m);
    #1;
    chk("idle_req", {31'b0, ram_req}, 32'd0);
    chk("idle_playing", {31'b0, playing}, 32'd0);
    chk("idle_eot", {31'b0, end_of_tape}, 32'd0);

    // header at offset 0 followed by one data byte
    img.delete();
    repeat (9) img.push_back(8'h00);
    set_hdr(0);
    img[8] = 8'h01;
    load_image(27'h100);
    finish_image(27'h100, "hdr0");

    img = '{8'h00, 8'hFF, 8'h55};
    load_image(27'h200);
    finish_image(27'h200, "plain3");

    // second header at offset 16 brings in a silence gap
    rand_image(26);
    set_hdr(0);
    set_hdr(16);
    load_image(27'h300);
    finish_image(27'h300, "hdr16");

    // motor pause mid-bit
    rand_image(12);
    load_image(27'h380);
    cyc = 0;
    while (!playing && cyc < 2000) begin
      @(posedge clk21m); #1;
      cyc++;
    end
    chk("play_start", {31'b0, playing}, 32'd1);
    repeat (20 + $urandom_range(0, 15)) @(posedge clk21m);
    #1;
    cas_motor = 1'b0;
    repeat (50) @(posedge clk21m);
    #1;
    cas_motor = 1'b1;
    finish_image(27'h380, "pause");

    mem_delay = 20;
    rand_image(2);
    load_image(27'h500);
    finish_image(27'h500, "slowack");
    mem_delay = -1;

    // reload while a read is outstanding; a stray late ack follows the abort
    rand_image(4);
    mem_delay = 20;
    load_image(27'h600);
    cyc = 0;
    while (reads.size() == 0 && cyc < 100) begin
      @(posedge clk21m); #1;
      cyc++;
    end
    chk("abort_req_seen", reads.size(), 32'd1);
    repeat (5) @(posedge clk21m);
    #1;
    chk("abort_req_held", {31'b0, ram_req}, 32'd1);
    late_arm = 1'b1;
    reads.delete();
    mem_delay = -1;
    img_load = 1'b1;
    @(posedge clk21m); #1;
    img_load = 1'b0;
    chk("abort_req_drop", {31'b0, ram_req}, 32'd0);
    finish_image(27'h600, "abort");

    img.delete();
    load_image(27'h0);
    chk("empty_eot", {31'b0, end_of_tape}, 32'd1);
    chk("empty_req", {31'b0, ram_req}, 32'd0);
    repeat (20) @(posedge clk21m);
    #1;
    chk("done_hold", {31'b0, end_of_tape}, 32'd1);
    chk("done_playing", {31'b0, playing}, 32'd0);

    for (int r = 0; r < 3; r++) begin
      rand_image($urandom_range(1, 20));
      if (img.size() >= 8 && $urandom_range(0, 1) == 1) set_hdr(0);
      if (img.size() >= 16 && $urandom_range(0, 1) == 1) set_hdr(8);
      load_image(27'($urandom_range(0, 3000)));
      finish_image(img_base, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
